seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Reverse path of the clock's BCD-to-segment encoder: watches the multiplexed display scan (digit-select plus 7-segment pattern) and recovers the BCD digits actually being shown. It filters scan transitions, decodes each stable pattern back to a digit code, and assembles one complete frame per scan. It sits beside the display driver as a self-test/readback monitor, letting the bench or a BIST compare shown time against counted time.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
- STABLE_CYCLES, 4, consecutive identical cycles required before a sample is accepted (1..255)
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- an_sel  in  NUM_DIGITS  digit enable, active-high, must be one-hot to be valid; bit k = position k
- seg  in  7  segment pattern, active-high, bit6=a … bit0=g
- digits_out  out  4*NUM_DIGITS  decoded frame; nibble k = position k
- frame_valid  out  1  one-cycle pulse when digits_out updates
- digit_err  out  NUM_DIGITS  per-position invalid-pattern flags for the published frame
- sync_lost  out  1  one-cycle pulse when a partial frame is dropped
- err_count  out  8  saturating invalid-pattern counter (only with macro, see Configuration)

## Operation
- Inputs are synchronous to clk; no synchronizer inside.
- Decode: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 00→4'hF (blank); any other pattern → 4'hE with digit_err bit set.
- Stability filter: registers previous {an_sel,seg}; counter clears on any change, increments while equal, saturates.
- Acceptance: one-cycle internal strobe on the STABLE_CYCLES-th consecutive identical cycle (counting the first), and only if an_sel is one-hot. Holding longer never re-accepts. an_sel all-zero or multi-hot: never accepted.
- FSM IDLE: accepted sample at position 0 → store nibble/err into shadow, expect=1, go COLLECT. Accepted sample at any other position → ignored, stay IDLE.
- FSM COLLECT: accepted sample at position expect → store; if expect==NUM_DIGITS-1, publish shadow to digits_out/digit_err, return to IDLE; else expect+1.
- COLLECT, accepted sample at wrong position → sync_lost pulse, shadow discarded; if that position is 0 restart (store, expect=1, stay COLLECT), else go IDLE.
- digits_out and digit_err hold the last published frame until the next publish.

## Timing
- Reset values: digits_out all 4'hF, digit_err 0, frame_valid 0, sync_lost 0, err_count 0, FSM IDLE, expect 0, stability counter 0.
- Acceptance strobe is combinational from registered state; shadow write on the following edge.
- Publish latency: digits_out, digit_err, and frame_valid update together on the edge after the last-position acceptance; frame_valid high exactly one cycle.
- sync_lost asserts on the edge after the offending acceptance, one cycle.
- STABLE_CYCLES=1: every change to a valid one-hot sample is accepted on its first cycle.
- Reset mid-frame: shadow and FSM cleared immediately (async); no frame_valid is produced for the interrupted scan.

## Configuration
- SEG_SCAN_ERR_COUNT_EN defined: err_count port present; increments by 1 on each accepted sample with an invalid pattern (blank is valid); saturates at 255; cleared only by reset.
- Undefined: err_count port and counter absent; all other behaviour identical.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4; scan positions 0..3 with patterns 30,6D,5B,7B, each held 6 cycles → one frame_valid, digits_out=16'h9521, digit_err=0.
- Same scan but each position held 3 cycles → no acceptance, no frame_valid, digits_out stays 16'hFFFF.
- Position 2 shows 0x01 → frame published with nibble 2 = 4'hE, digit_err=4'b0100; with SEG_SCAN_ERR_COUNT_EN, err_count=1; 300 such frames → err_count=255.
- Scan order 0,1,3 → sync_lost pulse on position 3, FSM IDLE; next full 0..3 scan publishes normally.
- an_sel=4'b0011 held 10 cycles mid-scan → ignored, no sync_lost; scan continues and publishes.
- Assert rst_n low after positions 0–1 accepted → outputs return to reset values; the following positions 2–3 produce no frame.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Display scan readback: filters the digit-select/segment scan and rebuilds BCD frames.
// Optional saturating invalid-pattern counter on err_count when SEG_SCAN_ERR_COUNT_EN is defined.
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an_sel,
   input  logic [6:0]              seg,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic                    frame_valid,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    sync_lost
`ifdef SEG_SCAN_ERR_COUNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_COLLECT = 1'b1;

   logic [NUM_DIGITS-1:0]   prev_an;
   logic [6:0]              prev_seg;
   logic [7:0]              cnt;
   logic                    onehot;
   logic                    accept;
   logic [PW-1:0]           pos;
   logic [3:0]              nib;
   logic                    bad;
   logic [0:0]              state;
   logic [PW-1:0]           exp_pos;
   logic                    last;
   logic [4*NUM_DIGITS-1:0] sh_d;
   logic [NUM_DIGITS-1:0]   sh_e;
   logic [4*NUM_DIGITS-1:0] sh_nx_d;
   logic [NUM_DIGITS-1:0]   sh_nx_e;

   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = 5'h00;
         7'h30:   r = 5'h01;
         7'h6D:   r = 5'h02;
         7'h79:   r = 5'h03;
         7'h33:   r = 5'h04;
         7'h5B:   r = 5'h05;
         7'h5F:   r = 5'h06;
         7'h70:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h7B:   r = 5'h09;
         7'h00:   r = 5'h0F;
         default: r = 5'h1E;
      endcase
      return r;
   endfunction

   // cnt counts repeats after the first cycle; it stops at STABLE_CYCLES so a
   // held sample hits the acceptance value exactly once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_an  <= '0;
         prev_seg <= '0;
         cnt      <= '0;
      end else begin
         prev_an  <= an_sel;
         prev_seg <= seg;
         if ({an_sel, seg} != {prev_an, prev_seg})
            cnt <= '0;
         else if (cnt != 8'(STABLE_CYCLES))
            cnt <= cnt + 8'd1;
      end
   end

   assign onehot = (prev_an != '0) &&
                   ((prev_an & (prev_an - 1'b1)) == '0);
   assign accept = onehot && (cnt == 8'(STABLE_CYCLES - 1));
   assign {bad, nib} = decode(prev_seg);
   assign last = (exp_pos == PW'(NUM_DIGITS - 1));

   always_comb begin
      pos     = '0;
      sh_nx_d = sh_d;
      sh_nx_e = sh_e;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (prev_an[k]) begin
            pos            = PW'(k);
            sh_nx_d[4*k+:4] = nib;
            sh_nx_e[k]     = bad;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         exp_pos     <= '0;
         sh_d        <= '1;
         sh_e        <= '0;
         digits_out  <= '1;
         digit_err   <= '0;
         frame_valid <= 1'b0;
         sync_lost   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_lost   <= 1'b0;
         if (accept) begin
            unique case (state)
               S_IDLE: begin
                  if (pos == '0) begin
                     sh_d    <= sh_nx_d;
                     sh_e    <= sh_nx_e;
                     exp_pos <= PW'(1);
                     state   <= S_COLLECT;
                  end
               end
               S_COLLECT: begin
                  if (pos == exp_pos) begin
                     sh_d <= sh_nx_d;
                     sh_e <= sh_nx_e;
                     if (last) begin
                        digits_out  <= sh_nx_d;
                        digit_err   <= sh_nx_e;
                        frame_valid <= 1'b1;
                        exp_pos     <= '0;
                        state       <= S_IDLE;
                     end else begin
                        exp_pos <= exp_pos + 1'b1;
                     end
                  end else begin
                     sync_lost <= 1'b1;
                     if (pos == '0) begin
                        sh_d    <= sh_nx_d;
                        sh_e    <= sh_nx_e;
                        exp_pos <= PW'(1);
                     end else begin
                        exp_pos <= '0;
                        state   <= S_IDLE;
                     end
                  end
               end
               default: begin
                  exp_pos <= '0;
                  state   <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef SEG_SCAN_ERR_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (accept && bad && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full scans plus
// hand-written sync-loss, multi-hot, reset and error-count sequences.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  an_sel;
   logic [6:0]  seg;
   logic [15:0] digits_out;
   logic        frame_valid;
   logic [3:0]  digit_err;
   logic        sync_lost;
`ifdef SEG_SCAN_ERR_COUNT_EN
   logic [7:0]  err_count;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fv_cnt    = 0;
   int sl_cnt    = 0;

   typedef struct {
      logic [27:0] pats;
      int          hold;
      int          frames;
      logic [15:0] digits;
      logic [3:0]  err;
   } vec_t;

   vec_t tbl[5];

   seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .an_sel      (an_sel),
      .seg         (seg),
      .digits_out  (digits_out),
      .frame_valid (frame_valid),
      .digit_err   (digit_err),
      .sync_lost   (sync_lost)
`ifdef SEG_SCAN_ERR_COUNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) fv_cnt++;
      if (sync_lost) sl_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask

   task automatic show(input logic [3:0] a, input logic [6:0] s,
                       input int n);
      an_sel = a;
      seg    = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan4(input logic [27:0] p, input int n);
      for (int k = 0; k < 4; k++)
         show(4'(1 << k), p[7*k+:7], n);
      show(4'b0000, 7'h00, 4);
   endtask

   initial begin
      // pats: position 0 in bits 6:0 ... position 3 in bits 27:21
      tbl[0] = '{ {7'h7B, 7'h5B, 7'h6D, 7'h30}, 3, 0, 16'hFFFF, 4'b0000 };
      tbl[1] = '{ {7'h7B, 7'h5B, 7'h6D, 7'h30}, 6, 1, 16'h9521, 4'b0000 };
      tbl[2] = '{ {7'h00, 7'h70, 7'h7F, 7'h7E}, 4, 1, 16'hF780, 4'b0000 };
      tbl[3] = '{ {7'h79, 7'h01, 7'h33, 7'h5F}, 5, 1, 16'h3E46, 4'b0100 };
      tbl[4] = '{ {7'h7B, 7'h5B, 7'h6D, 7'h30}, 6, 1, 16'h9521, 4'b0000 };

      rst_n  = 1'b0;
      an_sel = '0;
      seg    = '0;
      repeat (3) @(negedge clk);
      chk("rst_digits", 32'(digits_out), 32'hFFFF);
      chk("rst_err", 32'(digit_err), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);
      chk("rst_sl", 32'(sync_lost), 32'h0);
`ifdef SEG_SCAN_ERR_COUNT_EN
      chk("rst_errcnt", 32'(err_count), 32'h0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         fv_cnt = 0;
         scan4(tbl[i].pats, tbl[i].hold);
         chk($sformatf("v%0d_frames", i), 32'(fv_cnt), 32'(tbl[i].frames));
         chk($sformatf("v%0d_digits", i), 32'(digits_out), 32'(tbl[i].digits));
         chk($sformatf("v%0d_err", i), 32'(digit_err), 32'(tbl[i].err));
      end
`ifdef SEG_SCAN_ERR_COUNT_EN
      chk("errcnt_one", 32'(err_count), 32'h1);
`endif

      // order 0,1,3: drop partial frame, then stray 2,3 ignored in IDLE
      fv_cnt = 0;
      sl_cnt = 0;
      show(4'b0001, 7'h30, 6);
      show(4'b0010, 7'h6D, 6);
      show(4'b1000, 7'h7B, 6);
      show(4'b0000, 7'h00, 4);
      chk("sync_sl", 32'(sl_cnt), 32'h1);
      chk("sync_fv", 32'(fv_cnt), 32'h0);
      show(4'b0100, 7'h5B, 6);
      show(4'b1000, 7'h7B, 6);
      show(4'b0000, 7'h00, 4);
      chk("idle_stray_fv", 32'(fv_cnt), 32'h0);
      chk("idle_stray_sl", 32'(sl_cnt), 32'h1);
      scan4({7'h30, 7'h6D, 7'h5B, 7'h7B}, 6);
      chk("resync_fv", 32'(fv_cnt), 32'h1);
      chk("resync_digits", 32'(digits_out), 32'h1259);

      // multi-hot select held mid-scan is ignored
      fv_cnt = 0;
      sl_cnt = 0;
      show(4'b0001, 7'h7E, 6);
      show(4'b0010, 7'h30, 6);
      show(4'b0011, 7'h6D, 10);
      show(4'b0100, 7'h6D, 6);
      show(4'b1000, 7'h79, 6);
      show(4'b0000, 7'h00, 4);
      chk("mhot_fv", 32'(fv_cnt), 32'h1);
      chk("mhot_sl", 32'(sl_cnt), 32'h0);
      chk("mhot_digits", 32'(digits_out), 32'h3210);

      // reset after positions 0-1 accepted
      fv_cnt = 0;
      show(4'b0001, 7'h30, 6);
      show(4'b0010, 7'h6D, 6);
      an_sel = '0;
      seg    = '0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_digits", 32'(digits_out), 32'hFFFF);
      chk("mrst_err", 32'(digit_err), 32'h0);
`ifdef SEG_SCAN_ERR_COUNT_EN
      chk("mrst_errcnt", 32'(err_count), 32'h0);
`endif
      rst_n = 1'b1;
      show(4'b0100, 7'h5B, 6);
      show(4'b1000, 7'h7B, 6);
      show(4'b0000, 7'h00, 4);
      chk("mrst_fv", 32'(fv_cnt), 32'h0);
      chk("mrst_digits2", 32'(digits_out), 32'hFFFF);

`ifdef SEG_SCAN_ERR_COUNT_EN
      fv_cnt = 0;
      scan4({7'h7B, 7'h01, 7'h6D, 7'h30}, 4);
      chk("errcnt_after1", 32'(err_count), 32'h1);
      for (int f = 1; f < 300; f++)
         scan4({7'h7B, 7'h01, 7'h6D, 7'h30}, 4);
      chk("errcnt_frames", 32'(fv_cnt), 32'd300);
      chk("errcnt_sat", 32'(err_count), 32'hFF);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
